// File: rtl/stage_if.sv
// RV32I instruction fetch: owns the PC and assembles each instruction from four byte reads.
// Define ICACHE_EN to add a direct-mapped instruction cache in front of the byte port.
module stage_if #(
    parameter logic [31:0] RESET_PC       = 32'h0,
    parameter int          ICACHE_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_enable_i,
    input  logic [31:0] branch_addr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_grant_i,
    input  logic [7:0]  mem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [2:0]  req_cnt_reg;
    logic [2:0]  rcv_cnt_reg;
    logic        pending_reg;

    logic        cache_hit;
    logic [31:0] cache_word;
    logic        fetch_req;
    logic        accept;
    logic        capture;
    logic        capture_last;
    logic [31:0] fetched_word;

    assign fetch_req    = (state_reg == S_FETCH) && (req_cnt_reg < 3'd4) && !cache_hit;
    assign mem_req_o    = fetch_req;
    assign mem_addr_o   = fetch_req ? (pc_reg + {29'b0, req_cnt_reg}) : 32'h0;
    assign accept       = fetch_req && mem_grant_i;
    // pending_reg marks that mem_data_i carries the byte of last cycle's accepted request
    assign capture      = (state_reg == S_FETCH) && pending_reg;
    assign capture_last = capture && (rcv_cnt_reg == 3'd3);

    // Lanes 0..2 are buffered; lane 3 is taken straight from the bus on the final capture
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        logic [7:0] lane_reg;
        always_ff @(posedge clk) begin
            if (!rst && !branch_enable_i && capture && (rcv_cnt_reg == 3'(gi)))
                lane_reg <= mem_data_i;
        end
    end

    assign fetched_word = {mem_data_i, g_lane[2].lane_reg, g_lane[1].lane_reg, g_lane[0].lane_reg};

`ifdef ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [31:0]             cdata_mem [ICACHE_ENTRIES];
    logic [TAG_W-1:0]        ctag_mem  [ICACHE_ENTRIES];
    logic [ICACHE_ENTRIES-1:0] cvalid_reg;
    logic [IDX_W-1:0]        cache_idx;
    logic [TAG_W-1:0]        cache_tag;
    logic                    cache_fill;

    assign cache_idx  = pc_reg[IDX_W+1:2];
    assign cache_tag  = pc_reg[31:IDX_W+2];
    assign cache_hit  = (state_reg == S_FETCH) && (req_cnt_reg == 3'd0) &&
                        cvalid_reg[cache_idx] && (ctag_mem[cache_idx] == cache_tag);
    assign cache_word = cdata_mem[cache_idx];
    // A redirect on the filling edge aborts the fill along with the fetch
    assign cache_fill = capture_last && !branch_enable_i;

    always_ff @(posedge clk) begin
        if (rst)
            cvalid_reg <= '0;
        else if (cache_fill)
            cvalid_reg[cache_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst && cache_fill) begin
            cdata_mem[cache_idx] <= fetched_word;
            ctag_mem[cache_idx]  <= cache_tag;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_word = 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            pc_reg       <= RESET_PC;
            pc_o         <= 32'h0;
            inst_o       <= 32'h0;
            inst_valid_o <= 1'b0;
            req_cnt_reg  <= 3'd0;
            rcv_cnt_reg  <= 3'd0;
            pending_reg  <= 1'b0;
        end else if (state_reg == S_IDLE) begin
            state_reg <= S_FETCH;
        end else if (branch_enable_i) begin
            state_reg    <= S_FETCH;
            pc_reg       <= {branch_addr_i[31:2], 2'b00};
            inst_o       <= 32'h0;
            inst_valid_o <= 1'b0;
            req_cnt_reg  <= 3'd0;
            rcv_cnt_reg  <= 3'd0;
            pending_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (cache_hit) begin
                        inst_o       <= cache_word;
                        pc_o         <= pc_reg;
                        inst_valid_o <= 1'b1;
                        state_reg    <= S_HOLD;
                    end else begin
                        pending_reg <= accept;
                        if (accept)
                            req_cnt_reg <= req_cnt_reg + 3'd1;
                        if (capture)
                            rcv_cnt_reg <= rcv_cnt_reg + 3'd1;
                        if (capture_last) begin
                            inst_o       <= fetched_word;
                            pc_o         <= pc_reg;
                            inst_valid_o <= 1'b1;
                            state_reg    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        pc_reg       <= pc_reg + 32'd4;
                        inst_o       <= 32'h0;
                        inst_valid_o <= 1'b0;
                        req_cnt_reg  <= 3'd0;
                        rcv_cnt_reg  <= 3'd0;
                        pending_reg  <= 1'b0;
                        state_reg    <= S_FETCH;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// Scoreboard bench for stage_if: stimulus queues expected requests and instructions,
// a negedge monitor compares them against what the fetch stage presents.
module tb_stage_if;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_enable_i = 1'b0;
    logic [31:0] branch_addr_i = 32'h0;
    logic        mem_grant_i = 1'b1;
    logic [7:0]  mem_data_i = 8'hEE;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    stage_if #(.RESET_PC(32'h0), .ICACHE_ENTRIES(64)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .branch_enable_i(branch_enable_i), .branch_addr_i(branch_addr_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_grant_i(mem_grant_i), .mem_data_i(mem_data_i),
        .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [logic [31:0]];

    function automatic logic [7:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        mem[a]         = w[7:0];
        mem[a + 32'd1] = w[15:8];
        mem[a + 32'd2] = w[23:16];
        mem[a + 32'd3] = w[31:24];
    endtask

    // Byte returned the cycle after an accepted request; junk otherwise
    always @(posedge clk) mem_data_i <= (mem_req_o && mem_grant_i) ? rd(mem_addr_o) : 8'hEE;

    typedef struct { logic [31:0] pc; logic [31:0] inst; int at; } exp_t;
    typedef struct { logic [31:0] addr; int at; } req_t;
    exp_t exp_q[$];
    req_t req_q[$];

    int tests = 0;
    int fails = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic push_req(input logic [31:0] a, input int at);
        req_t r;
        r.addr = a; r.at = at;
        req_q.push_back(r);
    endtask

    task automatic push_fetch(input logic [31:0] pc, input int start);
        for (int i = 0; i < 4; i++) push_req(pc + 32'(i), start + i);
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst, input int at);
        exp_t e;
        e.pc = pc; e.inst = inst; e.at = at;
        exp_q.push_back(e);
    endtask

    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_inst = 32'h0;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (mem_req_o) begin
                if (req_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_req: got addr %h, expected no request (cycle %0d)", mem_addr_o, cyc);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    check32("req_addr", mem_addr_o, r.addr);
                    check32("req_cycle", 32'(cyc), 32'(r.at));
                end
            end
            if (inst_valid_o && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_valid: got pc %h inst %h, expected none", pc_o, inst_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("[TB] inst pc=%h inst=%h cycle=%0d (want pc=%h inst=%h cycle=%0d)",
                             pc_o, inst_o, cyc, e.pc, e.inst, e.at);
                    check32("pc_o", pc_o, e.pc);
                    check32("inst_o", inst_o, e.inst);
                    check32("valid_cycle", 32'(cyc), 32'(e.at));
                end
            end else if (inst_valid_o && prev_valid) begin
                check32("hold_pc", pc_o, prev_pc);
                check32("hold_inst", inst_o, prev_inst);
                check32("hold_no_req", {31'b0, mem_req_o}, 32'h0);
            end
            if (!inst_valid_o) check32("inst_zero_when_invalid", inst_o, 32'h0);
            prev_valid = inst_valid_o;
            prev_pc    = pc_o;
            prev_inst  = inst_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check32({tag, "_pc_o"}, pc_o, 32'h0);
        check32({tag, "_inst_o"}, inst_o, 32'h0);
        check32({tag, "_valid"}, {31'b0, inst_valid_o}, 32'h0);
        check32({tag, "_req"}, {31'b0, mem_req_o}, 32'h0);
        check32({tag, "_addr"}, mem_addr_o, 32'h0);
    endtask

    int e_s, f_s, g_s, h_s, i_s, j_s, k_s, l_s, p_s, m_s, n_s;
    bit cache_on;

    initial begin
`ifdef ICACHE_EN
        cache_on = 1'b1;
`else
        cache_on = 1'b0;
`endif
        put_word(32'h0000_0000, 32'h0010_0513);
        put_word(32'h0000_0004, 32'h0020_0593);
        put_word(32'h0000_0008, 32'h00B5_0633);
        put_word(32'h0000_1004, 32'h0000_8067);
        put_word(32'hFFFF_FFFC, 32'h0000_006F);
        put_word(32'h0000_0100, 32'h0FF0_0113);

        step(); step();
        check_reset("reset");

        // First fetch at RESET_PC, then stall three cycles past valid
        rst = 1'b0;
        e_s = cyc + 1;
        push_fetch(32'h0, e_s);
        push_exp(32'h0, 32'h0010_0513, e_s + 5);
        stall_i = 1'b1;
        step();
        repeat (8) step();
        stall_i = 1'b0;

        // Fetch at 4 with byte 2 refused twice
        f_s = e_s + 9;
        push_req(32'h4, f_s);     push_req(32'h5, f_s + 1);
        push_req(32'h6, f_s + 2); push_req(32'h6, f_s + 3);
        push_req(32'h6, f_s + 4); push_req(32'h7, f_s + 5);
        push_exp(32'h4, 32'h0020_0593, f_s + 7);
        step(); step(); step();
        mem_grant_i = 1'b0;
        step(); step();
        mem_grant_i = 1'b1;

        // Fetch at 8 redirected to 0x1006 while byte 1 is in flight
        g_s = f_s + 8;
        push_req(32'h8, g_s); push_req(32'h9, g_s + 1);
        repeat (5) step();
        branch_enable_i = 1'b1;
        branch_addr_i   = 32'h0000_1006;
        h_s = g_s + 2;
        push_fetch(32'h1004, h_s);
        push_exp(32'h1004, 32'h0000_8067, h_s + 5);
        step();
        branch_enable_i = 1'b0;
        repeat (5) step();

        // Redirect together with stall: redirect wins, low bits forced to zero
        stall_i         = 1'b1;
        branch_enable_i = 1'b1;
        branch_addr_i   = 32'hFFFF_FFFE;
        i_s = h_s + 6;
        push_fetch(32'hFFFF_FFFC, i_s);
        push_exp(32'hFFFF_FFFC, 32'h0000_006F, i_s + 5);
        j_s = i_s + 6;
        push_fetch(32'h0, j_s);
        push_exp(32'h0, 32'h0010_0513, j_s + 5);
        step();
        stall_i         = 1'b0;
        branch_enable_i = 1'b0;
        repeat (11) step();

        // Two fetches of 0x100: the second hits when the cache is built in
        branch_enable_i = 1'b1;
        branch_addr_i   = 32'h0000_0100;
        k_s = j_s + 6;
        push_fetch(32'h100, k_s);
        push_exp(32'h100, 32'h0FF0_0113, k_s + 5);
        step();
        branch_enable_i = 1'b0;
        repeat (5) step();
        branch_enable_i = 1'b1;
        l_s = k_s + 6;
        if (cache_on) begin
            push_exp(32'h100, 32'h0FF0_0113, l_s + 1);
            p_s = l_s + 2;
        end else begin
            push_fetch(32'h100, l_s);
            push_exp(32'h100, 32'h0FF0_0113, l_s + 5);
            p_s = l_s + 6;
        end
        push_req(32'h104, p_s); push_req(32'h105, p_s + 1);
        step();
        branch_enable_i = 1'b0;
        while (cyc < p_s + 1) step();

        // Reset in the middle of the fetch at 0x104
        rst = 1'b1;
        step(); step();
        check_reset("midreset");
        rst = 1'b0;
        m_s = cyc + 1;
        push_req(32'h0, m_s);
        step();
        branch_enable_i = 1'b1;
        branch_addr_i   = 32'h0000_0100;
        n_s = m_s + 1;
        push_fetch(32'h100, n_s);
        push_exp(32'h100, 32'h0FF0_0113, n_s + 5);
        step();
        branch_enable_i = 1'b0;
        stall_i = 1'b1;
        repeat (8) step();

        check32("req_queue_drained", 32'(req_q.size()), 32'h0);
        check32("exp_queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
